// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store sequencer: FSM states,
// RV32 load/store func3 encodings, access-size lookup and legality check.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    RESP  = 3'd5,
    ERR   = 3'd6
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  function automatic logic [2:0] size_bytes(input logic [1:0] f3_lo);
    case (f3_lo)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic f3_legal(input logic store, input logic [2:0] f3);
    if (store)
      return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Data-memory port: req/gnt address phase followed by an rvalid response phase.
interface lsu_ctrl_if;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_addr, mem_we, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr, mem_we, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane alignment: store byte enables / shifted data over two
// words, and load merge plus sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  func3,
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  input  logic [31:0] wdata,
  output logic [7:0]  be8,
  output logic [63:0] wd64,
  output logic [31:0] ld_data
);

  logic [2:0]  sz;
  logic [7:0]  mask;
  logic [63:0] merged;
  logic [31:0] raw;

  always_comb begin
    sz     = size_bytes(func3[1:0]);
    mask   = (8'd1 << sz) - 8'd1;
    be8    = mask << off;
    wd64   = {32'd0, wdata} << {off, 3'b000};
    // hi is zero for non-split loads, so the upper bytes shift in as zeros
    merged = {hi, lo} >> {off, 3'b000};
    raw    = merged[31:0];
    case (func3)
      F3_LB:   ld_data = {{24{raw[7]}}, raw[7:0]};
      F3_LH:   ld_data = {{16{raw[15]}}, raw[15:0]};
      F3_LBU:  ld_data = {24'd0, raw[7:0]};
      F3_LHU:  ld_data = {16'd0, raw[15:0]};
      default: ld_data = raw;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one pipeline request becomes one or two word-aligned
// memory transactions, with a single completion or fault pulse at the end.
module lsu_ctrl
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  lsu_ctrl_if.master  mem,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic [4:0]  ld_rd,
  output logic        st_done,
  output logic        fault,
  output logic        busy
);

  lsu_state_e  state;

  logic [1:0]  off_p0;
  logic [2:0]  func3_p0;
  logic        store_p0;
  logic [31:0] wdata_p0;
  logic [4:0]  rd_p0;
  logic        split_p0;
  logic [31:0] lo_p0;

  logic        idle;
  logic        legal;
  logic        split_in;
  logic [1:0]  a_off;
  logic [2:0]  a_func3;
  logic [31:0] a_wdata;
  logic [31:0] a_lo;
  logic [31:0] a_hi;
  logic [7:0]  be8;
  logic [63:0] wd64;
  logic [31:0] ext_data;

  logic        mem_req_r;
  logic [31:0] mem_addr_r;
  logic [3:0]  mem_we_r;
  logic [31:0] mem_wdata_r;
  logic [31:0] ld_data_r;
  logic [4:0]  ld_rd_r;

  assign idle     = (state == IDLE);
  assign legal    = f3_legal(req_store, req_func3);
  assign split_in = ({1'b0, req_addr[1:0]} + size_bytes(req_func3[1:0])) > 3'd4;

  // In IDLE the aligner sees the incoming request so word-0 lanes can be
  // registered on accept; afterwards it sees the captured request.
  assign a_off   = idle ? req_addr[1:0] : off_p0;
  assign a_func3 = idle ? req_func3     : func3_p0;
  assign a_wdata = idle ? req_wdata     : wdata_p0;
  assign a_lo    = (state == WAIT0) ? mem.mem_rdata : lo_p0;
  assign a_hi    = (state == WAIT1) ? mem.mem_rdata : 32'd0;

  lsu_align u_align (
    .off     (a_off),
    .func3   (a_func3),
    .lo      (a_lo),
    .hi      (a_hi),
    .wdata   (a_wdata),
    .be8     (be8),
    .wd64    (wd64),
    .ld_data (ext_data)
  );

  // Request capture (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (idle && req_valid) begin
      off_p0   <= req_addr[1:0];
      func3_p0 <= req_func3;
      store_p0 <= req_store;
      wdata_p0 <= req_wdata;
      rd_p0    <= req_rd;
      split_p0 <= split_in;
    end
    if (state == WAIT0 && mem.mem_rvalid)
      lo_p0 <= mem.mem_rdata;
  end

  // Sequencer and registered memory / result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mem_req_r   <= 1'b0;
      mem_addr_r  <= 32'd0;
      mem_we_r    <= 4'd0;
      mem_wdata_r <= 32'd0;
      ld_data_r   <= 32'd0;
      ld_rd_r     <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (legal) begin
              state       <= REQ0;
              mem_req_r   <= 1'b1;
              mem_addr_r  <= {req_addr[31:2], 2'b00};
              mem_we_r    <= req_store ? be8[3:0] : 4'd0;
              mem_wdata_r <= wd64[31:0];
            end else begin
              state <= ERR;
            end
          end
        end
        REQ0: begin
          if (mem.mem_gnt) begin
            mem_req_r <= 1'b0;
            state     <= WAIT0;
          end
        end
        WAIT0: begin
          if (mem.mem_rvalid) begin
            if (split_p0) begin
              state       <= REQ1;
              mem_req_r   <= 1'b1;
              mem_addr_r  <= mem_addr_r + 32'd4;
              mem_we_r    <= store_p0 ? be8[7:4] : 4'd0;
              mem_wdata_r <= wd64[63:32];
            end else begin
              state <= RESP;
              if (!store_p0) begin
                ld_data_r <= ext_data;
                ld_rd_r   <= rd_p0;
              end
            end
          end
        end
        REQ1: begin
          if (mem.mem_gnt) begin
            mem_req_r <= 1'b0;
            state     <= WAIT1;
          end
        end
        WAIT1: begin
          if (mem.mem_rvalid) begin
            state <= RESP;
            if (!store_p0) begin
              ld_data_r <= ext_data;
              ld_rd_r   <= rd_p0;
            end
          end
        end
        RESP:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready     = idle;
  assign busy          = ~idle;
  assign ld_valid      = (state == RESP) & ~store_p0;
  assign st_done       = (state == RESP) &  store_p0;
  assign fault         = (state == ERR);
  assign ld_data       = ld_data_r;
  assign ld_rd         = ld_rd_r;
  assign mem.mem_req   = mem_req_r;
  assign mem.mem_addr  = mem_addr_r;
  assign mem.mem_we    = mem_we_r;
  assign mem.mem_wdata = mem_wdata_r;

endmodule
